// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor cell works through the operands using a registered borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell on the current operand LSBs
  logic             d_bit;
  logic             bor_nx;
  logic [WIDTH-1:0] res_shift;

  assign d_bit     = a_q[0] ^ b_q[0] ^ bor_q;
  assign bor_nx    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // A start in the DONE cycle is accepted, giving back-to-back operation
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          bor_d   = 1'b0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        bor_d = bor_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = res_shift;
          borrow_d = bor_nx;
          ovf_d    = (a_msb_q != b_msb_q) & (res_shift[WIDTH-1] != a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == RUN);
  assign done_d = (state_d == DONE);

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus
// back-to-back, ignored-start and mid-operation reset sequences.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bor;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done; returns edges counted since start acceptance
  task automatic wait_done(input int lat0, output int lat, output bit busy_bad);
    lat      = lat0;
    busy_bad = 1'b0;
    while (!done && lat < 20) begin
      if (!busy) busy_bad = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    bit busy_bad;
    start = 1'b1;
    a     = ia;
    b     = ib;
    tick();
    start = 1'b0;
    a     = '0;
    b     = '0;
    wait_done(0, lat, busy_bad);
    chk({nm, " latency"}, 32'(lat), 32'd8);
    chk({nm, " busy_run"}, 32'(busy_bad), 32'd0);
    chk({nm, " diff"}, 32'(diff), 32'(ed));
    chk({nm, " borrow"}, 32'(borrow_out), 32'(eb));
    chk({nm, " overflow"}, 32'(overflow), 32'(eo));
    chk({nm, " busy_in_done"}, 32'(busy), 32'd0);
    tick();
    chk({nm, " done_1cyc"}, 32'(done), 32'd0);
    chk({nm, " diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int lat;
    bit busy_bad;
    bit saw_done;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bor: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bor: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bor: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, diff: 8'h00, bor: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bor: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bor: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'hC3, b: 8'h5A, diff: 8'h69, bor: 1'b0, ovf: 1'b1};

    start = 1'b0;
    a     = '0;
    b     = '0;
    rstn  = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst diff", 32'(diff), 32'd0);
    chk("rst borrow", 32'(borrow_out), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor, vecs[i].ovf);

    // Start pulse three cycles into RUN must be ignored
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      if (lat == 2) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("ign latency", 32'(lat), 32'd8);
    chk("ign diff", 32'(diff), 32'h0F);
    chk("ign borrow", 32'(borrow_out), 32'd0);

    // Back-to-back start issued in the done cycle
    start = 1'b1;
    a     = 8'h20;
    b     = 8'h30;
    tick();
    start = 1'b0;
    chk("b2b done_low", 32'(done), 32'd0);
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b diff_hold", 32'(diff), 32'h0F);
    wait_done(0, lat, busy_bad);
    chk("b2b latency", 32'(lat), 32'd8);
    chk("b2b busy_run", 32'(busy_bad), 32'd0);
    chk("b2b diff", 32'(diff), 32'hF0);
    chk("b2b borrow", 32'(borrow_out), 32'd1);
    chk("b2b overflow", 32'(overflow), 32'd0);
    tick();

    // Reset mid-operation aborts without a done
    start = 1'b1;
    a     = 8'h40;
    b     = 8'h01;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort diff", 32'(diff), 32'd0);
    chk("abort borrow", 32'(borrow_out), 32'd0);
    tick();
    rstn     = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort no_done", 32'(saw_done), 32'd0);

    run_op("post_rst", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Inverse arithmetic companion to the team's full-adder cell; used where area matters more than latency.
- Operands are captured on a start pulse; the result is presented with a one-cycle done strobe and held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a new subtraction; sampled on the rising edge of clk.
- a  input  WIDTH  minuend; sampled only on an accepted start.
- b  input  WIDTH  subtrahend; sampled only on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle strobe; result outputs are valid from this cycle on.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  unsigned borrow, i.e. a < b as unsigned values.
- overflow  output  1  signed overflow of a - b.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; busy, done, borrow_out and overflow = 0; diff = 0; all internal shift registers, bit counter and borrow flop = 0.
- State IDLE: busy = 0. On start = 1, latch a and b into shift registers, clear the borrow flop, clear the bit counter, then go to RUN.
- State RUN: busy = 1. Each cycle uses a0/b0 = current shift-register LSBs:
  - d = a0 ^ b0 ^ bor
  - bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor)
  - d is shifted into the result shift register at the MSB end (right shift).
  - Both operand registers shift right by one.
  - The counter increments; after the WIDTH-th bit, go to DONE.
- State DONE, one cycle long:
  - done = 1, busy = 0.
  - diff, borrow_out and overflow are loaded from the internal result on the edge that enters DONE.
  - overflow = (a_msb != b_msb) & (diff_msb != a_msb), using the latched operand MSBs.
  - Next state is IDLE, or RUN if start = 1 in this cycle.
- Latency: start sampled at edge k; bits processed on edges k+1 .. k+WIDTH; done high from edge k+WIDTH to edge k+WIDTH+1. Total latency is WIDTH cycles from start acceptance to done.
- start while busy (RUN): ignored; operands are not re-sampled and the operation in flight is unaffected.
- start in the DONE cycle: accepted (back-to-back). New operands are latched, done still pulses for the completing operation, and busy rises on the next edge.
- Outputs diff, borrow_out and overflow hold their last values through IDLE and through the next RUN. They change only on entry to DONE or on reset.
- done is never high for two consecutive cycles, and is never high together with busy.
- Reset asserted mid-operation: immediate abort to IDLE with all outputs 0. No done is produced for the aborted operation.
- Width rules:
  - The counter is $clog2(WIDTH)+1 bits wide.
  - Arithmetic is modulo 2^WIDTH.
  - The borrow is exactly the carry-out inverse of a + ~b + 1.

Test Plan:
- WIDTH=8. rstn low for 2 cycles, then release -> busy = done = diff = borrow_out = overflow = 0 and state idle.
- start with a=0x05, b=0x03 -> exactly 8 cycles later done = 1 for one cycle with diff=0x02, borrow_out=0, overflow=0. busy is high during the 8 RUN cycles.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- a=0x00, b=0x00 -> diff=0x00, all flags 0. Then a=0xFF, b=0xFF -> diff=0x00, flags 0.
- start a=0x10, b=0x01, then pulse start with a=0xAA, b=0x55 three cycles later -> second start ignored, result diff=0x0F. Then assert start with a=0x20, b=0x30 in the done cycle -> second done exactly 8 cycles later with diff=0xF0, borrow_out=1.
- start a=0x40, b=0x01, then drop rstn at RUN bit 4 -> outputs go to 0 immediately and no done follows. After release, a=0x09, b=0x04 -> diff=0x05.
